// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage ahead of the L1 I-cache.
//
// Holds the fetch PC and keeps at most one line request outstanding. Each
// 64-bit response is split into 32-bit instructions, which are written into a
// circular fetch queue. Decode drains that queue through a valid/ready
// handshake. A redirect flushes the queue and restarts fetch. If a request is
// still outstanding when the redirect arrives, its response is dropped.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   fetch restart; redirect_pc[1:0] ignored
//   ic_req_valid/addr/ready       I-cache request channel
//   ic_resp_valid/data/error      I-cache response (two instructions, or fault)
//   dec_valid/instr/pc/fault      queue head presented to decode
//   dec_ready                     decode consumes the head
//   perf_fetch_cnt/stall_cnt      performance counters (tied 0 when disabled)
//
// Build option: define FETCH_PERF_CNT_EN to instantiate the perf counters.
//
// state   | meaning
// F_ISSUE | may present a request when the queue has room for a full line
// F_WAIT  | request accepted, waiting for the response (may be a dropped one)
// F_HALT  | fetch fault pushed; idle until redirect
module fetch_stage #(
  parameter int                     PADDR_WIDTH = 56,
  parameter logic [PADDR_WIDTH-1:0] RESET_PC    = 56'h0000_0000_8000_0000,
  parameter int                     FQ_DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [PADDR_WIDTH-1:0] redirect_pc,
  output logic                   ic_req_valid,
  output logic [PADDR_WIDTH-1:0] ic_req_addr,
  input  logic                   ic_req_ready,
  input  logic                   ic_resp_valid,
  input  logic [63:0]            ic_resp_data,
  input  logic                   ic_resp_error,
  output logic                   dec_valid,
  output logic [31:0]            dec_instr,
  output logic [PADDR_WIDTH-1:0] dec_pc,
  output logic                   dec_fault,
  input  logic                   dec_ready,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_stall_cnt
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  // Highest occupancy that still leaves room for a two-instruction line.
  localparam logic [CW-1:0] ISSUE_MAX = CW'(FQ_DEPTH - 2);

  typedef enum logic [1:0] {F_ISSUE, F_WAIT, F_HALT} state_t;

  state_t                   state_q, state_d;
  logic [PADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                     drop_q, drop_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [CW-1:0]            count_q, count_d;

  logic [31:0]              fq_instr_q [FQ_DEPTH];
  logic [PADDR_WIDTH-1:0]   fq_pc_q    [FQ_DEPTH];
  logic                     fq_fault_q [FQ_DEPTH];

  logic                     push0_en, push1_en, push0_fault;
  logic [31:0]              push0_instr, push1_instr;
  logic [PADDR_WIDTH-1:0]   push0_pc, push1_pc;
  logic [1:0]               n_push;
  logic                     pop, resp_evt;
  logic [PADDR_WIDTH-1:0]   line_base, redirect_pc_al;
  logic                     unused_pc_lsb;

  assign line_base      = {fetch_pc_q[PADDR_WIDTH-1:3], 3'b000};
  assign redirect_pc_al = {redirect_pc[PADDR_WIDTH-1:2], 2'b00};
  assign unused_pc_lsb  = ^redirect_pc[1:0];
  assign resp_evt       = ic_resp_valid | ic_resp_error;
  assign wr_ptr_p1      = wr_ptr_q + PW'(1);

  assign ic_req_valid = !rst && (state_q == F_ISSUE) && !redirect_valid && (count_q <= ISSUE_MAX);
  assign ic_req_addr  = fetch_pc_q;

  // Masking on dec_valid keeps the head outputs at zero when the queue is empty,
  // so the storage array does not need a reset.
  assign dec_valid = (count_q != '0);
  assign dec_instr = dec_valid ? fq_instr_q[rd_ptr_q] : '0;
  assign dec_pc    = dec_valid ? fq_pc_q[rd_ptr_q]    : '0;
  assign dec_fault = dec_valid ? fq_fault_q[rd_ptr_q] : 1'b0;
  assign pop       = dec_valid & dec_ready;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_d      = drop_q;
    push0_en    = 1'b0;
    push1_en    = 1'b0;
    push0_fault = 1'b0;
    push0_instr = ic_resp_data[63:32];
    push0_pc    = fetch_pc_q;
    push1_instr = ic_resp_data[63:32];
    push1_pc    = line_base + PADDR_WIDTH'(4);

    case (state_q)
      F_ISSUE: if (ic_req_valid && ic_req_ready) state_d = F_WAIT;
      F_WAIT: begin
        if (resp_evt) begin
          state_d = F_ISSUE;
          drop_d  = 1'b0;
          if (!drop_q) begin
            push0_en = 1'b1;
            if (ic_resp_error) begin
              push0_instr = '0;
              push0_fault = 1'b1;
              state_d     = F_HALT;
            end else begin
              // On an even-word PC the low half goes first and the high half
              // follows in slot 1. On an odd-word PC only the high half is used.
              if (!fetch_pc_q[2]) begin
                push0_instr = ic_resp_data[31:0];
                push1_en    = 1'b1;
              end
              fetch_pc_d = line_base + PADDR_WIDTH'(8);
            end
          end
        end
      end
      F_HALT: ;
      default: state_d = F_ISSUE;
    endcase

    // Redirect overrides everything. A response in the same cycle is consumed
    // here. Without one, the request still in flight must be dropped later.
    if (redirect_valid) begin
      push0_en   = 1'b0;
      push1_en   = 1'b0;
      fetch_pc_d = redirect_pc_al;
      if (state_q == F_WAIT && !resp_evt) begin
        state_d = F_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = F_ISSUE;
        drop_d  = 1'b0;
      end
    end

    n_push = {1'b0, push0_en} + {1'b0, push1_en};

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(n_push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(n_push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= F_ISSUE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_en) begin
      fq_instr_q[wr_ptr_q] <= push0_instr;
      fq_pc_q[wr_ptr_q]    <= push0_pc;
      fq_fault_q[wr_ptr_q] <= push0_fault;
    end
    if (push1_en) begin
      fq_instr_q[wr_ptr_p1] <= push1_instr;
      fq_pc_q[wr_ptr_p1]    <= push1_pc;
      fq_fault_q[wr_ptr_p1] <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;
  logic [1:0]  n_good;

  always_comb begin
    n_good       = {1'b0, push0_en & ~push0_fault} + {1'b0, push1_en};
    perf_fetch_d = perf_fetch_q + 32'(n_good);
    perf_stall_d = perf_stall_q + 32'((state_q == F_ISSUE) && (count_q > ISSUE_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int          DEPTH = 8;
  localparam logic [55:0] RPC   = 56'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [55:0] redirect_pc = '0;
  logic        ic_req_valid;
  logic [55:0] ic_req_addr;
  logic        ic_req_ready = 1'b0;
  logic        ic_resp_valid = 1'b0;
  logic [63:0] ic_resp_data = '0;
  logic        ic_resp_error = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [55:0] dec_pc;
  logic        dec_fault;
  logic        dec_ready = 1'b0;
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_error(ic_resp_error),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_fault(dec_fault),
    .dec_ready(dec_ready), .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the queue as a list of entries plus the fetch PC and the
  // outstanding/dropped/halted status of the single request.
  typedef struct {
    logic [31:0] instr;
    logic [55:0] pc;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [55:0] m_pc;
  bit          m_out, m_drop, m_halt;
  int          m_lat;
  logic [31:0] m_fetch, m_stall;

  // Advance one clock, then apply the inputs for the cycle that follows.
  // Outputs are settled on return.
  task automatic cyc(input logic redir, input logic [55:0] rpc, input logic drdy,
                     input logic qrdy, input logic rv, input logic [63:0] rd, input logic re);
    @(posedge clk);
    #1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    dec_ready      = drdy;
    ic_req_ready   = qrdy;
    ic_resp_valid  = rv;
    ic_resp_data   = rd;
    ic_resp_error  = re;
    #1;
  endtask

  task automatic idle(input logic drdy);
    cyc(1'b0, '0, drdy, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = RPC; m_out = 0; m_drop = 0; m_halt = 0; m_lat = 0;
    m_fetch = '0; m_stall = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic bit exp_req();
    return !m_out && !m_halt && !redirect_valid && ((DEPTH - mq.size()) >= 2);
  endfunction

  // Apply the effect of the upcoming clock edge to the model, using the inputs
  // currently driven.
  task automatic model_update();
    bit          resp;
    logic [55:0] base;
    resp = ic_resp_valid || ic_resp_error;
    if (!m_out && !m_halt && (DEPTH - mq.size()) < 2) m_stall++;
    if (redirect_valid) begin
      mq.delete();
      m_pc   = redirect_pc & ~56'h3;
      m_halt = 0;
      if (m_out && !resp) m_drop = 1;
      else begin m_out = 0; m_drop = 0; end
    end else begin
      if (dec_ready && mq.size() != 0) void'(mq.pop_front());
      if (exp_req() && ic_req_ready) begin
        m_out = 1;
        m_lat = $urandom_range(0, 3);
      end else if (m_out && resp) begin
        m_out = 0;
        if (m_drop) m_drop = 0;
        else if (ic_resp_error) begin
          mq.push_back('{instr: 32'h0, pc: m_pc, fault: 1'b1});
          m_halt = 1;
        end else begin
          base = m_pc & ~56'h7;
          if (!m_pc[2]) begin
            mq.push_back('{instr: ic_resp_data[31:0], pc: base, fault: 1'b0});
            m_fetch++;
          end
          mq.push_back('{instr: ic_resp_data[63:32], pc: base + 56'd4, fault: 1'b0});
          m_fetch++;
          m_pc = base + 56'd8;
        end
      end
    end
    if (m_out && !resp && m_lat > 0) m_lat--;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    tests++; if (ic_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got=%0b exp=0", ic_req_valid); end
    tests++; if (ic_req_addr !== RPC) begin fails++; $display("FAIL reset_req_addr got=%h exp=%h", ic_req_addr, RPC); end
    tests++; if ({dec_valid, dec_fault} !== 2'b00) begin fails++; $display("FAIL reset_dec_flags got=%b exp=00", {dec_valid, dec_fault}); end
    tests++; if (dec_instr !== 32'h0 || dec_pc !== 56'h0) begin fails++; $display("FAIL reset_dec_data got=%h/%h exp=0/0", dec_instr, dec_pc); end
    tests++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin fails++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    tests++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 56'h8000_0000) begin fails++; $display("FAIL basic_req got=%0b@%h exp=1@80000000", ic_req_valid, ic_req_addr); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h0000_0013_0000_0093, 1'b0);
    tests++; if (ic_req_valid !== 1'b0) begin fails++; $display("FAIL basic_wait_req got=%0b exp=0", ic_req_valid); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    tests++; if (dec_valid !== 1'b1 || dec_instr !== 32'h93 || dec_pc !== 56'h8000_0000) begin fails++; $display("FAIL basic_first got=%0b %h@%h exp=1 00000093@80000000", dec_valid, dec_instr, dec_pc); end
    tests++; if (ic_req_addr !== 56'h8000_0008 || ic_req_valid !== 1'b1) begin fails++; $display("FAIL basic_next_addr got=%0b@%h exp=1@80000008", ic_req_valid, ic_req_addr); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    tests++; if (dec_valid !== 1'b1 || dec_instr !== 32'h13 || dec_pc !== 56'h8000_0004) begin fails++; $display("FAIL basic_second got=%0b %h@%h exp=1 00000013@80000004", dec_valid, dec_instr, dec_pc); end
    idle(1'b0);
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL basic_drained got=%0b exp=0", dec_valid); end
  endtask

  task automatic test_redirect_odd();
    do_reset();
    cyc(1'b1, 56'h8000_0104, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    tests++; if (ic_req_valid !== 1'b0) begin fails++; $display("FAIL odd_req_during_redirect got=%0b exp=0", ic_req_valid); end
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    tests++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 56'h8000_0104) begin fails++; $display("FAIL odd_req got=%0b@%h exp=1@80000104", ic_req_valid, ic_req_addr); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    tests++; if (dec_valid !== 1'b1 || dec_instr !== 32'hAAAA_AAAA || dec_pc !== 56'h8000_0104) begin fails++; $display("FAIL odd_head got=%0b %h@%h exp=1 aaaaaaaa@80000104", dec_valid, dec_instr, dec_pc); end
    tests++; if (ic_req_addr !== 56'h8000_0108) begin fails++; $display("FAIL odd_next_addr got=%h exp=80000108", ic_req_addr); end
    idle(1'b0);
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL odd_single_entry got=%0b exp=0", dec_valid); end
  endtask

  task automatic test_stale_drop();
    bit saw_req;
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cyc(1'b1, 56'h8000_2000, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    saw_req = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (ic_req_valid) saw_req = 1;
    end
    tests++; if (saw_req) begin fails++; $display("FAIL stale_req_while_dropping got=1 exp=0"); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL stale_dropped got=%0b exp=0", dec_valid); end
    tests++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 56'h8000_2000) begin fails++; $display("FAIL stale_restart got=%0b@%h exp=1@80002000", ic_req_valid, ic_req_addr); end
  endtask

  task automatic test_full();
    bit saw_req;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      tests++; if (ic_req_valid !== 1'b1) begin fails++; $display("FAIL full_req%0d got=%0b exp=1", i, ic_req_valid); end
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, {32'(2 * i + 1), 32'(2 * i)}, 1'b0);
    end
    saw_req = 0;
    for (int j = 0; j < 5; j++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (ic_req_valid) saw_req = 1;
    end
    tests++; if (saw_req) begin fails++; $display("FAIL full_blocked got=1 exp=0"); end
`ifdef FETCH_PERF_CNT_EN
    tests++; if (perf_stall_cnt !== 32'd4 || perf_fetch_cnt !== 32'd8) begin fails++; $display("FAIL full_perf got=%0d/%0d exp=8/4", perf_fetch_cnt, perf_stall_cnt); end
`else
    tests++; if (perf_stall_cnt !== 32'd0 || perf_fetch_cnt !== 32'd0) begin fails++; $display("FAIL full_perf_off got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      tests++;
      if (dec_valid !== 1'b1 || dec_instr !== 32'(k) || dec_pc !== 56'h8000_0000 + 56'(4 * k)) begin
        fails++; $display("FAIL full_drain%0d got=%0b %h@%h exp=1 %h@%h", k, dec_valid, dec_instr, dec_pc, 32'(k), 56'h8000_0000 + 56'(4 * k));
      end
    end
  endtask

  task automatic test_fault();
    bit saw_req;
    do_reset();
    cyc(1'b1, 56'h8000_0040, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    tests++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 56'h8000_0040) begin fails++; $display("FAIL fault_req got=%0b@%h exp=1@80000040", ic_req_valid, ic_req_addr); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    idle(1'b0);
    tests++; if (dec_valid !== 1'b1 || dec_fault !== 1'b1 || dec_pc !== 56'h8000_0040 || dec_instr !== 32'h0) begin
      fails++; $display("FAIL fault_entry got=%0b f%0b %h@%h exp=1 f1 00000000@80000040", dec_valid, dec_fault, dec_instr, dec_pc);
    end
    saw_req = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      if (ic_req_valid) saw_req = 1;
    end
    tests++; if (saw_req) begin fails++; $display("FAIL fault_halted got=1 exp=0"); end
    cyc(1'b1, 56'h8000_0100, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tests++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 56'h8000_0100) begin fails++; $display("FAIL fault_restart got=%0b@%h exp=1@80000100", ic_req_valid, ic_req_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(1'b1, 56'hFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    tests++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 56'hFF_FFFF_FFFF_FFF8) begin fails++; $display("FAIL wrap_req got=%0b@%h exp=1@fffffffffffff8", ic_req_valid, ic_req_addr); end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h2222_2222_1111_1111, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    tests++; if (dec_instr !== 32'h1111_1111 || dec_pc !== 56'hFF_FFFF_FFFF_FFF8) begin fails++; $display("FAIL wrap_first got=%h@%h exp=11111111@fffffffffffff8", dec_instr, dec_pc); end
    tests++; if (ic_req_addr !== 56'h0) begin fails++; $display("FAIL wrap_next_addr got=%h exp=0", ic_req_addr); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    tests++; if (dec_instr !== 32'h2222_2222 || dec_pc !== 56'hFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_second got=%h@%h exp=22222222@fffffffffffffc", dec_instr, dec_pc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      logic        redir, rv, re;
      logic [55:0] rpc;
      redir = ($urandom_range(0, 11) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? 56'hFF_FFFF_FFFF_FFF0 + 56'($urandom_range(0, 15))
                                          : 56'h8000_0000 + 56'($urandom_range(0, 4095));
      rv    = m_out && (m_lat == 0);
      re    = rv && ($urandom_range(0, 15) == 0);
      cyc(redir, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rv,
          {$urandom, $urandom}, re);
      tests++; if (ic_req_valid !== exp_req()) begin fails++; $display("FAIL rnd_req_valid cyc=%0d got=%0b exp=%0b", n, ic_req_valid, exp_req()); end
      tests++; if (ic_req_addr !== m_pc) begin fails++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", n, ic_req_addr, m_pc); end
      tests++; if (dec_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rnd_dec_valid cyc=%0d got=%0b exp=%0b", n, dec_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        tests++;
        if ({dec_instr, dec_pc, dec_fault} !== {mq[0].instr, mq[0].pc, mq[0].fault}) begin
          fails++; $display("FAIL rnd_head cyc=%0d got=%h@%h f%0b exp=%h@%h f%0b", n, dec_instr, dec_pc, dec_fault, mq[0].instr, mq[0].pc, mq[0].fault);
        end
      end
      model_update();
    end
    idle(1'b0);
`ifdef FETCH_PERF_CNT_EN
    tests++; if (perf_fetch_cnt !== m_fetch) begin fails++; $display("FAIL rnd_perf_fetch got=%0d exp=%0d", perf_fetch_cnt, m_fetch); end
    tests++; if (perf_stall_cnt !== m_stall) begin fails++; $display("FAIL rnd_perf_stall got=%0d exp=%0d", perf_stall_cnt, m_stall); end
`else
    tests++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin fails++; $display("FAIL rnd_perf_off got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_redirect_odd();
    test_stale_drop();
    test_full();
    test_fault();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage directly upstream of the L1 instruction cache. Owns the fetch PC, issues one line-offset request at a time to the I-cache, and splits each 64-bit response into 32-bit instructions. Those instructions go into a small fetch queue that feeds decode with a valid/ready handshake. Handles redirects (branch/exception/FENCE.I restart) and fetch faults, including dropping a stale in-flight cache response.

## Interface
Parameters:
- PADDR_WIDTH, 56: physical fetch address width.
- RESET_PC, 56'h0000_0000_8000_0000: fetch PC after reset.
- FQ_DEPTH, 8: fetch-queue entries (32-bit instruction each); power of two, at least 4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  restart fetch at redirect_pc; flushes queue.
- redirect_pc  in  PADDR_WIDTH  new fetch PC; bits [1:0] ignored (treated as 0).
- ic_req_valid  out  1  fetch request to I-cache.
- ic_req_addr  out  PADDR_WIDTH  current fetch PC.
- ic_req_ready  in  1  I-cache accepts request.
- ic_resp_valid  in  1  I-cache response.
- ic_resp_data  in  64  two instructions: [31:0] at addr&~7, [63:32] at (addr&~7)+4.
- ic_resp_error  in  1  fetch access fault.
- dec_valid  out  1  queue head valid.
- dec_instr  out  32  head instruction.
- dec_pc  out  PADDR_WIDTH  head instruction PC.
- dec_fault  out  1  head entry is a fetch fault.
- dec_ready  in  1  decode consumes head.
- perf_fetch_cnt  out  32  instructions pushed (see Configuration).
- perf_stall_cnt  out  32  cycles queue full-blocked (see Configuration).

## Operation
- FSM states: F_ISSUE, F_WAIT, F_HALT. At most one request outstanding.
- F_ISSUE: ic_req_valid = !redirect_valid && free >= 2, where free = FQ_DEPTH - count. On ic_req_valid && ic_req_ready, go to F_WAIT.
- F_WAIT with ic_resp_valid, no drop flag, no error:
  - If fetch_pc[2]=0, push both halves with PCs fetch_pc and fetch_pc+4.
  - If fetch_pc[2]=1, push only [63:32] with PC fetch_pc.
  - fetch_pc <= (fetch_pc & ~7) + 8, modulo 2^PADDR_WIDTH. Go to F_ISSUE.
- F_WAIT with ic_resp_error: push one entry (instr 0, fault 1, PC fetch_pc) and go to F_HALT.
- F_HALT: no requests until redirect.
- Redirect, any state:
  - Queue count <= 0 and fetch_pc <= redirect_pc&~3.
  - From F_WAIT: set drop flag and stay in F_WAIT. The next response, error or not, is discarded, the flag clears, and the FSM goes to F_ISSUE.
  - From F_ISSUE or F_HALT: go to F_ISSUE.
- Simultaneous events:
  - Redirect and response in the same cycle: the response is discarded, the flag stays clear, and the FSM goes to F_ISSUE.
  - Redirect beats a same-cycle pop and push.
  - Push and pop in the same cycle: count += pushed - popped.
- The queue is a circular buffer with wrapping rd/wr pointers and a count of width clog2(FQ_DEPTH)+1. The free >= 2 issue rule guarantees no overflow.

## Timing
- Reset values:
  - State F_ISSUE, fetch_pc RESET_PC, queue empty, drop flag 0.
  - ic_req_valid 0 while rst is high; ic_req_addr = RESET_PC.
  - dec_valid, dec_instr, dec_pc, dec_fault all 0; perf counters 0.
- ic_req_valid and ic_req_addr are combinational from registered state and redirect_valid. The request is accepted in the same cycle it is presented.
- A response pushed in cycle N appears on dec_* in cycle N+1; there is no bypass.
- A redirect in cycle N allows a request to redirect_pc in cycle N+1 (F_ISSUE case).
- dec_* are driven from the queue head register; dec_valid = count != 0.

## Configuration
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments by the number of non-fault entries pushed per cycle.
  - perf_stall_cnt increments each cycle in F_ISSUE with free < 2.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Reset, RESET_PC=0x8000_0000, cache answers 1 cycle after accept with 64'h0000_0013_0000_0093 → decode sees 0x00000093 @0x80000000, then 0x00000013 @0x80000004; next ic_req_addr 0x80000008.
- Redirect to 0x8000_0104, response {0xAAAAAAAA, 0xBBBBBBBB} → only 0xAAAAAAAA @0x80000104 is pushed; next request 0x80000108.
- Request to 0x80000000 with 10-cycle miss, redirect to 0x80002000 in cycle 3 → late response discarded, queue empty; next request 0x80002000 issued the cycle after the response.
- dec_ready=0 with FQ_DEPTH=8 → 4 responses fill the queue, then ic_req_valid stays 0. With macro defined, perf_stall_cnt counts those cycles.
- ic_resp_error on 0x80000040 → single entry with dec_fault=1, dec_pc=0x80000040; no requests until redirect to 0x80000100 restarts fetch there.
- Redirect to 2^56-8 → pushes two instructions; next ic_req_addr = 0 (wrap).
